// File: rtl/crc_request_arbiter.sv
// crc_request_arbiter: round-robin front end sharing one multi-cycle
// CRC engine among REQUESTERS clients, with a result watchdog.

module crc_request_arbiter #(
  parameter int REQUESTERS = 4,
  parameter int DATAWIDTH  = 128,
  parameter int POLYWIDTH  = 8,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REQUESTERS-1:0] req_valid_i,
  input  logic [REQUESTERS*(DATAWIDTH+POLYWIDTH)-1:0] req_data_i,
  output logic [REQUESTERS-1:0] req_ready_o,
  output logic [REQUESTERS-1:0] resp_valid_o,
  input  logic [REQUESTERS-1:0] resp_ready_i,
  output logic [DATAWIDTH+POLYWIDTH-1:0] resp_data_o,
  output logic                  resp_ok_o,
  output logic                  resp_err_o,
  output logic                  eng_start_o,
  output logic [DATAWIDTH+POLYWIDTH-1:0] eng_data_o,
  input  logic                  eng_busy_i,
  input  logic                  eng_valid_i,
  input  logic [DATAWIDTH+POLYWIDTH-1:0] eng_data_i
);

  localparam int VW = DATAWIDTH + POLYWIDTH;
  localparam int IW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int SW = IW + 1;
  localparam int WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IW-1:0]   r_gnt;
  logic [IW-1:0]   w_pick;
  logic [SW-1:0]   w_sum;
  logic            w_any;
  logic            w_accept;
  logic [VW-1:0]   r_vec;
  logic [VW-1:0]   r_rdata;
  logic [VW-1:0]   w_rdata_nxt;
  logic            r_ok;
  logic            w_ok_nxt;
  logic            r_err;
  logic            w_err_nxt;
  logic [WW-1:0]   r_wdog;
  logic [WW-1:0]   w_wdog_nxt;

  // Scan from farthest to nearest so the nearest valid client wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_gnt;
    w_sum  = '0;
    for (int k = REQUESTERS; k >= 1; k--) begin
      w_sum = {1'b0, r_gnt} + SW'(k);
      if (w_sum >= SW'(REQUESTERS)) begin
        w_sum = w_sum - SW'(REQUESTERS);
      end
      if (req_valid_i[w_sum[IW-1:0]]) begin
        w_any  = 1'b1;
        w_pick = w_sum[IW-1:0];
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_any;

  // Held low during reset so no accept strobe escapes.
  always_comb begin
    req_ready_o = '0;
    if (w_accept && !rst_i) begin
      req_ready_o[w_pick] = 1'b1;
    end
  end

  always_comb begin
    resp_valid_o = '0;
    if (r_state == S_RESP) begin
      resp_valid_o[r_gnt] = 1'b1;
    end
  end

  assign eng_start_o = (r_state == S_ISSUE);
  assign eng_data_o  = eng_start_o ? r_vec : '0;
  assign resp_data_o = r_rdata;
  assign resp_ok_o   = r_ok;
  assign resp_err_o  = r_err;

  always_comb begin
    w_state_nxt = r_state;
    w_wdog_nxt  = r_wdog;
    w_rdata_nxt = r_rdata;
    w_ok_nxt    = r_ok;
    w_err_nxt   = r_err;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!eng_busy_i) begin
          w_state_nxt = S_WAIT;
          w_wdog_nxt  = '0;
        end
      end
      S_WAIT: begin
        if (eng_valid_i) begin
          w_rdata_nxt = eng_data_i;
          w_ok_nxt    = ~|eng_data_i[POLYWIDTH-1:0];
          w_err_nxt   = 1'b0;
          w_state_nxt = S_RESP;
        end else if (r_wdog == WW'(TIMEOUT - 1)) begin
          w_rdata_nxt = '0;
          w_ok_nxt    = 1'b0;
          w_err_nxt   = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_wdog_nxt  = r_wdog + WW'(1);
        end
      end
      S_RESP: begin
        if (resp_ready_i[r_gnt]) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_gnt   <= IW'(REQUESTERS - 1);
      r_vec   <= '0;
      r_rdata <= '0;
      r_ok    <= 1'b0;
      r_err   <= 1'b0;
      r_wdog  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wdog  <= w_wdog_nxt;
      r_rdata <= w_rdata_nxt;
      r_ok    <= w_ok_nxt;
      r_err   <= w_err_nxt;
      if (w_accept) begin
        r_gnt <= w_pick;
        r_vec <= req_data_i[int'(w_pick)*VW +: VW];
      end
    end
  end

endmodule

// File: tb/tb_crc_request_arbiter.sv
// tb_crc_request_arbiter: directed bench with a transaction-level
// reference model and a poly 0x07 CRC engine model.

module tb_crc_request_arbiter;

  localparam int R  = 4;
  localparam int DW = 8;
  localparam int PW = 8;
  localparam int VW = DW + PW;
  localparam int TO = 16;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [R-1:0]  req_valid_i;
  logic [R*VW-1:0] req_data_i;
  logic [R-1:0]  req_ready_o;
  logic [R-1:0]  resp_valid_o;
  logic [R-1:0]  resp_ready_i;
  logic [VW-1:0] resp_data_o;
  logic          resp_ok_o;
  logic          resp_err_o;
  logic          eng_start_o;
  logic [VW-1:0] eng_data_o;
  logic          eng_busy_i;
  logic          eng_valid_i;
  logic [VW-1:0] eng_data_i;

  crc_request_arbiter #(
    .REQUESTERS(R),
    .DATAWIDTH(DW),
    .POLYWIDTH(PW),
    .TIMEOUT(TO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .req_valid_i(req_valid_i),
    .req_data_i(req_data_i),
    .req_ready_o(req_ready_o),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o),
    .resp_ok_o(resp_ok_o),
    .resp_err_o(resp_err_o),
    .eng_start_o(eng_start_o),
    .eng_data_o(eng_data_o),
    .eng_busy_i(eng_busy_i),
    .eng_valid_i(eng_valid_i),
    .eng_data_i(eng_data_i)
  );

  always #5 clk_i = ~clk_i;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Remainder of the 16-bit {data,crc} word modulo x^8+x^2+x+1.
  function automatic logic [7:0] crc_rem(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 15; i >= 8; i--) begin
      if (r[i]) r = r ^ (16'h0107 << (i - 8));
    end
    return r[7:0];
  endfunction

  // Engine model.
  logic        e_busy = 1'b0;
  logic        e_valid = 1'b0;
  logic        e_hold = 1'b0;
  logic        e_never = 1'b0;
  logic [15:0] e_res = '0;
  int          e_lat = 2;
  int          e_cnt = 0;

  assign eng_busy_i  = e_busy | e_hold;
  assign eng_valid_i = e_valid;
  assign eng_data_i  = e_valid ? e_res : 16'hA5A5;

  initial begin
    logic        s_take;
    logic        s_rst;
    logic [15:0] s_vec;
    forever begin
      @(negedge clk_i);
      s_take = eng_start_o && !eng_busy_i;
      s_rst  = rst_i;
      s_vec  = eng_data_o;
      @(posedge clk_i);
      #1;
      e_valid = 1'b0;
      if (s_rst) begin
        e_busy = 1'b0;
        e_cnt  = 0;
      end else if (s_take) begin
        e_busy = 1'b1;
        e_cnt  = e_lat;
        e_res  = {s_vec[15:8], crc_rem(s_vec)};
      end else if (e_busy) begin
        e_cnt--;
        if (e_cnt == 0) begin
          e_busy = 1'b0;
          if (!e_never) e_valid = 1'b1;
        end
      end
    end
  end

  // Reference model: one open transaction described by flags and
  // the cycle stamp of engine acceptance.
  logic        m_open = 1'b0;
  logic        m_issued = 1'b0;
  logic        m_done = 1'b0;
  int          m_client = 0;
  int          m_last = R - 1;
  int          m_t_acc = 0;
  logic [15:0] m_vec = '0;
  logic [15:0] m_rdata = '0;
  logic        m_ok = 1'b0;
  logic        m_err = 1'b0;

  function automatic int pick(input logic [R-1:0] v, input int last);
    int best;
    int bd;
    int d;
    best = -1;
    bd = R + 1;
    for (int c = 0; c < R; c++) begin
      if (v[c]) begin
        d = (c - last - 1 + 2 * R) % R;
        if (d < bd) begin
          bd = d;
          best = c;
        end
      end
    end
    return best;
  endfunction

  logic [R-1:0]  x_rdy;
  logic [R-1:0]  x_rv;
  logic          x_st;
  logic [15:0]   x_ed;
  logic [15:0]   x_rd;
  logic          x_ok;
  logic          x_err;

  always @(negedge clk_i) begin
    x_rdy = '0;
    x_rv  = '0;
    x_st  = 1'b0;
    x_ed  = '0;
    x_rd  = '0;
    x_ok  = 1'b0;
    x_err = 1'b0;
    if (!rst_i) begin
      if (!m_open && req_valid_i != '0) begin
        x_rdy[pick(req_valid_i, m_last)] = 1'b1;
      end
      x_st = m_open && !m_issued;
      x_ed = x_st ? m_vec : 16'h0;
      if (m_done) x_rv[m_client] = 1'b1;
      x_rd  = m_rdata;
      x_ok  = m_ok;
      x_err = m_err;
    end
    chk("m_req_ready", req_ready_o, x_rdy);
    chk("m_resp_valid", resp_valid_o, x_rv);
    chk("m_eng_start", eng_start_o, x_st);
    chk("m_eng_data", eng_data_o, x_ed);
    chk("m_resp_data", resp_data_o, x_rd);
    chk("m_resp_ok", resp_ok_o, x_ok);
    chk("m_resp_err", resp_err_o, x_err);
    if (rst_i) begin
      m_open   = 1'b0;
      m_issued = 1'b0;
      m_done   = 1'b0;
      m_last   = R - 1;
      m_rdata  = '0;
      m_ok     = 1'b0;
      m_err    = 1'b0;
    end else if (!m_open) begin
      if (req_valid_i != '0) begin
        m_client = pick(req_valid_i, m_last);
        m_last   = m_client;
        m_vec    = req_data_i[m_client*VW +: VW];
        m_open   = 1'b1;
        m_issued = 1'b0;
        m_done   = 1'b0;
      end
    end else if (!m_issued) begin
      if (!eng_busy_i) begin
        m_issued = 1'b1;
        m_t_acc  = cyc;
      end
    end else if (!m_done) begin
      if (eng_valid_i) begin
        m_done  = 1'b1;
        m_rdata = eng_data_i;
        m_ok    = (eng_data_i[7:0] == 8'h00);
        m_err   = 1'b0;
      end else if (cyc - m_t_acc == TO) begin
        m_done  = 1'b1;
        m_rdata = '0;
        m_ok    = 1'b0;
        m_err   = 1'b1;
      end
    end else if (resp_ready_i[m_client]) begin
      m_open   = 1'b0;
      m_issued = 1'b0;
      m_done   = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wait_grant(output int g, input int budget);
    g = -1;
    for (int i = 0; i < budget && g < 0; i++) begin
      @(negedge clk_i);
      for (int b = 0; b < R; b++) if (req_ready_o[b]) g = b;
    end
    if (g < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL grant_timeout: got no req_ready_o, expected one within %0d cycles",
               budget);
    end
  endtask

  task automatic wait_resp(output int t, input int budget);
    t = -1;
    for (int i = 0; i < budget && t < 0; i++) begin
      @(negedge clk_i);
      if (resp_valid_o != '0) t = cyc;
    end
    if (t < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL resp_timeout: got no resp_valid_o, expected one within %0d cycles",
               budget);
    end
  endtask

  task automatic wait_issue(output int c, input int budget);
    c = -1;
    for (int i = 0; i < budget && c < 0; i++) begin
      @(negedge clk_i);
      if (eng_start_o && !eng_busy_i) c = cyc;
    end
    if (c < 0) begin
      n_chk++;
      n_err++;
      $display("FAIL issue_timeout: got no engine accept, expected one within %0d cycles",
               budget);
    end
  endtask

  task automatic send(input int c, input logic [15:0] v);
    int g;
    tick();
    req_valid_i[c] = 1'b1;
    req_data_i[c*VW +: VW] = v;
    wait_grant(g, 40);
    chk("grant_client", g, c);
    if (g >= 0) chk("ready_onehot", req_ready_o, 32'(1 << c));
    tick();
    req_valid_i[c] = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  int g_rr[6];
  int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
  int t;
  int c;
  logic [15:0] held;

  initial begin
    rst_i        = 1'b1;
    req_valid_i  = '0;
    req_data_i   = '0;
    resp_ready_i = '1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_eng_start", eng_start_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    tick();
    rst_i = 1'b0;

    // Single request from client 1.
    send(1, 16'h0100);
    @(negedge clk_i);
    chk("t1_start", eng_start_o, 1);
    chk("t1_eng_data", eng_data_o, 16'h0100);
    chk("t1_ready_gone", req_ready_o, 0);
    wait_resp(t, 60);
    chk("t1_resp_valid", resp_valid_o, 4'b0010);
    chk("t1_resp_data", resp_data_o, 16'h0107);
    chk("t1_resp_ok", resp_ok_o, 0);
    chk("t1_resp_err", resp_err_o, 0);

    // Check mode: vectors carrying their own CRC.
    send(0, 16'h0107);
    wait_resp(t, 60);
    chk("t2a_resp_data", resp_data_o, 16'h0100);
    chk("t2a_resp_ok", resp_ok_o, 1);
    send(0, 16'hFFF3);
    wait_resp(t, 60);
    chk("t2b_resp_data", resp_data_o, 16'hFF00);
    chk("t2b_resp_ok", resp_ok_o, 1);

    // Round-robin with all clients requesting continuously.
    do_reset();
    req_data_i  = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    req_valid_i = '1;
    for (int i = 0; i < 6; i++) begin
      wait_grant(g_rr[i], 60);
      chk("rr_order", g_rr[i], exp_rr[i]);
      if (i > 0) chk("rr_no_repeat", g_rr[i] != g_rr[i-1], 1);
    end
    tick();
    req_valid_i = '0;
    wait_resp(t, 60);
    chk("rr_last_resp", resp_valid_o, 4'b0010);

    // Backpressure on client 2 while client 3 waits.
    tick();
    resp_ready_i = 4'b1011;
    req_valid_i[2] = 1'b1;
    req_data_i[2*VW +: VW] = 16'h0200;
    wait_grant(c, 40);
    chk("bp_grant2", c, 2);
    tick();
    req_valid_i[2] = 1'b0;
    req_valid_i[3] = 1'b1;
    req_data_i[3*VW +: VW] = 16'h0300;
    wait_resp(t, 60);
    chk("bp_resp_data", resp_data_o, 16'h020E);
    held = resp_data_o;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk_i);
      chk("bp_hold_valid", resp_valid_o, 4'b0100);
      chk("bp_hold_data", resp_data_o, held);
      chk("bp_no_ready", req_ready_o, 0);
      chk("bp_no_start", eng_start_o, 0);
    end
    tick();
    resp_ready_i = '1;
    @(negedge clk_i);
    chk("bp_release_valid", resp_valid_o, 4'b0100);
    tick();
    @(negedge clk_i);
    chk("bp_grant3", req_ready_o, 4'b1000);
    tick();
    req_valid_i[3] = 1'b0;
    wait_resp(t, 60);
    chk("bp_resp3_data", resp_data_o, 16'h0309);

    // Watchdog: engine never answers.
    e_never = 1'b1;
    send(0, 16'hAB00);
    wait_issue(c, 40);
    wait_resp(t, 60);
    chk("wd_latency", t - (c + 1), TO);
    chk("wd_err", resp_err_o, 1);
    chk("wd_data", resp_data_o, 0);
    chk("wd_ok", resp_ok_o, 0);
    e_never = 1'b0;

    // Pulse on the last watchdog cycle still wins.
    e_lat = 15;
    send(0, 16'h5500);
    wait_issue(c, 40);
    wait_resp(t, 60);
    chk("wd15_latency", t - (c + 1), TO);
    chk("wd15_err", resp_err_o, 0);
    chk("wd15_data", resp_data_o, 16'h55AC);

    // One cycle late: error, and the late pulse is ignored.
    e_lat = 16;
    send(0, 16'h5500);
    wait_issue(c, 40);
    wait_resp(t, 60);
    chk("wd16_latency", t - (c + 1), TO);
    chk("wd16_err", resp_err_o, 1);
    chk("wd16_data", resp_data_o, 0);

    // Engine busy holds ISSUE without running the watchdog.
    e_lat  = 2;
    e_hold = 1'b1;
    send(1, 16'h0300);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      chk("busy_start", eng_start_o, 1);
      chk("busy_eng_data", eng_data_o, 16'h0300);
      tick();
    end
    e_hold = 1'b0;
    wait_resp(t, 60);
    chk("busy_err", resp_err_o, 0);
    chk("busy_data", resp_data_o, 16'h0309);

    // Reset in WAIT drops the transaction.
    e_lat = 10;
    send(2, 16'h0200);
    wait_issue(c, 40);
    repeat (3) tick();
    rst_i = 1'b1;
    req_valid_i = '1;
    @(negedge clk_i);
    chk("rw_req_ready", req_ready_o, 0);
    chk("rw_resp_valid", resp_valid_o, 0);
    chk("rw_eng_start", eng_start_o, 0);
    chk("rw_eng_data", eng_data_o, 0);
    chk("rw_resp_data", resp_data_o, 0);
    chk("rw_flags", {resp_ok_o, resp_err_o}, 0);
    tick();
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("rw_grant0", req_ready_o, 4'b0001);
    tick();
    req_valid_i = '0;
    e_lat = 2;
    wait_resp(t, 60);
    chk("rw_resp_client0", resp_valid_o, 4'b0001);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected one by 200000");
    $fatal(1, "bench timeout");
  end

endmodule
